// File: rtl/axis_pkg.sv
// Shared types, defaults and byte-enable helpers for the AXI-Stream header
// strip path.
package axis_pkg;

    localparam int DEF_DATA_WD      = 32;
    localparam int DEF_DATA_BYTE_WD = DEF_DATA_WD / 8;
    localparam int DEF_BYTE_CNT_WD  = $clog2(DEF_DATA_BYTE_WD);
    localparam int DEF_CNT_W        = DEF_BYTE_CNT_WD + 1;

    typedef logic [DEF_DATA_WD-1:0]      data_t;
    typedef logic [DEF_DATA_BYTE_WD-1:0] keep_t;
    typedef logic [DEF_CNT_W-1:0]        cnt_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HDR   = 2'd1,
        BODY  = 2'd2,
        FLUSH = 2'd3
    } state_e;

    // n ones packed against the MSB (byte 0 side)
    function automatic keep_t keep_msb(cnt_t n);
        keep_t k;
        k = '0;
        for (int i = 0; i < DEF_DATA_BYTE_WD; i++)
            if (i < int'(n)) k[DEF_DATA_BYTE_WD-1-i] = 1'b1;
        return k;
    endfunction

    // n ones packed against the LSB
    function automatic keep_t keep_lsb(cnt_t n);
        keep_t k;
        k = '0;
        for (int i = 0; i < DEF_DATA_BYTE_WD; i++)
            if (i < int'(n)) k[i] = 1'b1;
        return k;
    endfunction

    function automatic cnt_t popcount_keep(keep_t keep);
        cnt_t c;
        c = '0;
        for (int i = 0; i < DEF_DATA_BYTE_WD; i++)
            c = c + cnt_t'(keep[i]);
        return c;
    endfunction

    // Zero every byte whose enable is clear so shifted garbage never leaks
    function automatic data_t mask_data(data_t d, keep_t keep);
        data_t m;
        m = d;
        for (int i = 0; i < DEF_DATA_BYTE_WD; i++)
            if (!keep[DEF_DATA_BYTE_WD-1-i]) m[DEF_DATA_WD-1-8*i -: 8] = 8'h00;
        return m;
    endfunction

endpackage

// File: rtl/axi_stream_strip_header_if.sv
// Single AXI-Stream channel: payload plus valid/ready handshake.
interface axi_stream_strip_header_if #(
    parameter int DATA_WD = axis_pkg::DEF_DATA_WD
) ();
    localparam int DATA_BYTE_WD = DATA_WD / 8;

    logic                    valid;
    logic [DATA_WD-1:0]      data;
    logic [DATA_BYTE_WD-1:0] keep;
    logic                    last;
    logic                    ready;

    modport master (output valid, data, keep, last, input ready);
    modport slave  (input valid, data, keep, last, output ready);
endinterface

// File: rtl/axis_out_slice.sv
// Single-entry registered output stage; holds its beat stable under
// backpressure and tells the core when a new beat may be loaded.
module axis_out_slice #(
    parameter int DATA_WD      = axis_pkg::DEF_DATA_WD,
    parameter int DATA_BYTE_WD = DATA_WD / 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [DATA_WD-1:0]      data,
    input  logic [DATA_BYTE_WD-1:0] keep,
    input  logic                    last,
    output logic                    can_accept,
    axi_stream_strip_header_if.master m
);

    // Load only when empty or the held beat is leaving this cycle
    assign can_accept = !m.valid || m.ready;

    // Output register; a load without push empties the slice
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m.valid <= 1'b0;
            m.data  <= '0;
            m.keep  <= '0;
            m.last  <= 1'b0;
        end else if (can_accept) begin
            m.valid <= push;
            m.data  <= push ? data : '0;
            m.keep  <= push ? keep : '0;
            m.last  <= push & last;
        end
    end

endmodule

// File: rtl/axi_stream_strip_header.sv
// Strips the first N bytes of each packet onto a header sideband and
// re-packs the remaining payload MSB-aligned on the output stream.
module axi_stream_strip_header
    import axis_pkg::*;
#(
    parameter int DATA_WD      = DEF_DATA_WD,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst,
    axi_stream_strip_header_if.slave  s_in,
    axi_stream_strip_header_if.master m_out,
    input  logic                    valid_strip,
    input  logic [BYTE_CNT_WD:0]    byte_strip_cnt,
    output logic                    ready_strip,
    output logic                    valid_header,
    output logic [DATA_WD-1:0]      header_out,
    output logic [DATA_BYTE_WD-1:0] keep_header,
    output logic                    header_short
);

    localparam int CNT_W = BYTE_CNT_WD + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DATA_BYTE_WD);

    state_e                  state, state_next;
    logic [CNT_W-1:0]        n_q, n_next, rem_q, rem_next;
    logic [CNT_W-1:0]        r, k, wk, cmd_n;
    logic [CNT_W+2:0]        sh_n, sh_r, sh_wk;
    logic [DATA_WD-1:0]      residue, res_next, d;
    logic [DATA_WD-1:0]      push_data, hdr_data;
    logic [DATA_BYTE_WD-1:0] push_keep, hdr_keep;
    logic                    push, push_last, hdr_load, hdr_short;
    logic                    can_accept, ready_in, beat;

    // r: residue bytes carried between beats; shifts are in bits
    assign r     = FULL - n_q;
    assign k     = popcount_keep(s_in.keep);
    assign wk    = FULL - k;
    assign sh_n  = {n_q, 3'b000};
    assign sh_r  = {r, 3'b000};
    assign sh_wk = {wk, 3'b000};
    assign d     = mask_data(s_in.data, s_in.keep);
    assign cmd_n = (byte_strip_cnt > FULL) ? FULL : byte_strip_cnt;

    assign ready_strip = (state == IDLE) && !rst;
    assign ready_in    = ((state == HDR) || (state == BODY)) && can_accept;
    assign s_in.ready  = ready_in;
    assign beat        = s_in.valid && ready_in;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state, output-beat composition and header capture
    always_comb begin
        state_next = state;
        n_next     = n_q;
        rem_next   = rem_q;
        res_next   = residue;
        push       = 1'b0;
        push_data  = '0;
        push_keep  = '0;
        push_last  = 1'b0;
        hdr_load   = 1'b0;
        hdr_data   = '0;
        hdr_keep   = '0;
        hdr_short  = 1'b0;
        case (state)
            IDLE: begin
                if (valid_strip) begin
                    n_next     = cmd_n;
                    rem_next   = '0;
                    res_next   = '0;
                    state_next = HDR;
                end
            end
            HDR: begin
                if (beat) begin
                    hdr_load = 1'b1;
                    hdr_data = d >> sh_r;
                    hdr_keep = keep_lsb(n_q);
                    res_next = d << sh_n;
                    if (!s_in.last) begin
                        // N=0 forwards beat 0 directly rather than parking it
                        if (n_q == '0) begin
                            push      = 1'b1;
                            push_data = d;
                            push_keep = '1;
                            res_next  = '0;
                        end
                        state_next = BODY;
                    end else if (k > n_q) begin
                        push       = 1'b1;
                        push_data  = d << sh_n;
                        push_keep  = keep_msb(k - n_q);
                        push_last  = 1'b1;
                        res_next   = '0;
                        state_next = IDLE;
                    end else begin
                        // Packet ended inside the header: report what arrived
                        hdr_data   = d >> sh_wk;
                        hdr_keep   = keep_lsb(k);
                        hdr_short  = 1'b1;
                        res_next   = '0;
                        state_next = IDLE;
                    end
                end
            end
            BODY: begin
                if (beat) begin
                    push = 1'b1;
                    if (n_q == '0) begin
                        push_data = d;
                        push_keep = s_in.last ? keep_msb(k) : '1;
                        push_last = s_in.last;
                        if (s_in.last) state_next = IDLE;
                    end else begin
                        push_data = residue | (d >> sh_r);
                        push_keep = '1;
                        res_next  = d << sh_n;
                        if (s_in.last) begin
                            if (k <= n_q) begin
                                push_keep  = keep_msb(r + k);
                                push_last  = 1'b1;
                                res_next   = '0;
                                state_next = IDLE;
                            end else begin
                                // Tail spills past this word; drain it next
                                rem_next   = k - n_q;
                                state_next = FLUSH;
                            end
                        end
                    end
                end
            end
            FLUSH: begin
                if (can_accept) begin
                    push       = 1'b1;
                    push_data  = residue;
                    push_keep  = keep_msb(rem_q);
                    push_last  = 1'b1;
                    res_next   = '0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Packet context and header sideband registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q          <= '0;
            rem_q        <= '0;
            residue      <= '0;
            valid_header <= 1'b0;
            header_out   <= '0;
            keep_header  <= '0;
            header_short <= 1'b0;
        end else begin
            n_q          <= n_next;
            rem_q        <= rem_next;
            residue      <= res_next;
            valid_header <= hdr_load;
            if (hdr_load) begin
                header_out   <= hdr_data;
                keep_header  <= hdr_keep;
                header_short <= hdr_short;
            end
        end
    end

    axis_out_slice #(
        .DATA_WD     (DATA_WD),
        .DATA_BYTE_WD(DATA_BYTE_WD)
    ) u_out_slice (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .data      (push_data),
        .keep      (push_keep),
        .last      (push_last),
        .can_accept(can_accept),
        .m         (m_out)
    );

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Directed scoreboard bench for axi_stream_strip_header.
module tb_axi_stream_strip_header;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ready_out = 1'b1;
    logic        valid_strip = 1'b0;
    logic [2:0]  byte_strip_cnt = '0;
    logic        ready_strip;
    logic        valid_header;
    logic [31:0] header_out;
    logic [3:0]  keep_header;
    logic        header_short;

    axi_stream_strip_header_if #(.DATA_WD(32)) s_in ();
    axi_stream_strip_header_if #(.DATA_WD(32)) m_out ();

    assign m_out.ready = ready_out;

    axi_stream_strip_header dut (
        .clk           (clk),
        .rst           (rst),
        .s_in          (s_in),
        .m_out         (m_out),
        .valid_strip   (valid_strip),
        .byte_strip_cnt(byte_strip_cnt),
        .ready_strip   (ready_strip),
        .valid_header  (valid_header),
        .header_out    (header_out),
        .keep_header   (keep_header),
        .header_short  (header_short)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] d; logic [3:0] k; logic l; } beat_t;
    typedef struct { logic [31:0] d; logic [3:0] k; logic s; } hdr_t;
    beat_t exp_q[$];
    hdr_t  hdr_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic       bp_en = 1'b0;
    logic       rdy_hold = 1'b1;
    logic [5:0] bp_pat = 6'b101001;   // bit0 first: 1,0,0,1,0,1
    int         bp_idx = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm, input logic [31:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %h with nothing expected", nm, act);
    endtask

    task automatic exp_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        beat_t b;
        b.d = d; b.k = k; b.l = l;
        exp_q.push_back(b);
    endtask

    task automatic exp_hdr(input logic [31:0] d, input logic [3:0] k, input logic s);
        hdr_t h;
        h.d = d; h.k = k; h.s = s;
        hdr_q.push_back(h);
    endtask

    // Called at posedge+1; returns at posedge+1 after the handshake edge
    task automatic send_cmd(input logic [2:0] n);
        int t = 0;
        logic got = 1'b0;
        valid_strip = 1'b1;
        byte_strip_cnt = n;
        do begin
            @(negedge clk); got = ready_strip;
            @(posedge clk); #1; t++;
        end while (!got && t < 200);
        if (!got) fail_now("cmd_timeout", 32'(t));
        valid_strip = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] dd, input logic [3:0] kk, input logic ll);
        int t = 0;
        logic got = 1'b0;
        s_in.valid = 1'b1;
        s_in.data  = dd;
        s_in.keep  = kk;
        s_in.last  = ll;
        do begin
            @(negedge clk); got = s_in.ready;
            @(posedge clk); #1; t++;
        end while (!got && t < 200);
        if (!got) fail_now("beat_timeout", 32'(t));
        s_in.valid = 1'b0;
        s_in.data  = '0;
        s_in.keep  = '0;
        s_in.last  = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || hdr_q.size() != 0) && t < 100) begin
            @(posedge clk); #1; t++;
        end
        chk("drain_out", 32'(exp_q.size()), 32'd0);
        chk("drain_hdr", 32'(hdr_q.size()), 32'd0);
    endtask

    task automatic run_t2();
        exp_hdr(32'h00001122, 4'b0011, 1'b0);
        exp_beat(32'h33445566, 4'b1111, 1'b0);
        exp_beat(32'h778899AA, 4'b1111, 1'b0);
        exp_beat(32'hBB000000, 4'b1000, 1'b1);
        send_cmd(3'd2);
        send_beat(32'h11223344, 4'b1111, 1'b0);
        send_beat(32'h55667788, 4'b1111, 1'b0);
        send_beat(32'h99AABBCC, 4'b1110, 1'b1);
    endtask

    task automatic run_t1();
        exp_hdr(32'h000A0B0C, 4'b0111, 1'b0);
        exp_beat(32'h0D0E0F00, 4'b1111, 1'b0);
        exp_beat(32'h01020300, 4'b1110, 1'b1);
        send_cmd(3'd3);
        send_beat(32'h0A0B0C0D, 4'b1111, 1'b0);
        send_beat(32'h0E0F0001, 4'b1111, 1'b0);
        send_beat(32'h0203DEAD, 4'b1100, 1'b1);
    endtask

    // Downstream ready driver
    initial begin
        forever begin
            @(posedge clk); #1;
            if (bp_en) begin
                ready_out = bp_pat[bp_idx];
                bp_idx = (bp_idx + 1) % 6;
            end else begin
                ready_out = rdy_hold;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents something
    initial begin
        beat_t e;
        hdr_t  h;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (m_out.valid && ready_out) begin
                    if (exp_q.size() == 0) fail_now("out_extra", m_out.data);
                    else begin
                        e = exp_q.pop_front();
                        chk("out_data", m_out.data, e.d);
                        chk("out_keep", 32'(m_out.keep), 32'(e.k));
                        chk("out_last", 32'(m_out.last), 32'(e.l));
                    end
                end
                if (m_out.valid && !ready_out)
                    chk("ready_in_stall", 32'(s_in.ready), 32'd0);
                if (valid_header) begin
                    if (hdr_q.size() == 0) fail_now("hdr_extra", header_out);
                    else begin
                        h = hdr_q.pop_front();
                        chk("hdr_data", header_out, h.d);
                        chk("hdr_keep", 32'(keep_header), 32'(h.k));
                        chk("hdr_short", 32'(header_short), 32'(h.s));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0t expected finish", $time);
        $fatal(1, "timeout");
    end

    // Stimulus
    initial begin
        s_in.valid = 1'b0;
        s_in.data  = '0;
        s_in.keep  = '0;
        s_in.last  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid_out", 32'(m_out.valid), 32'd0);
        chk("rst_data_out", m_out.data, 32'd0);
        chk("rst_keep_out", 32'(m_out.keep), 32'd0);
        chk("rst_ready_in", 32'(s_in.ready), 32'd0);
        chk("rst_ready_strip", 32'(ready_strip), 32'd0);
        chk("rst_valid_header", 32'(valid_header), 32'd0);
        chk("rst_header_out", header_out, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // T1: N=3 with residue ending inside the last word
        run_t1();
        drain();

        // T2: N=2 with tail spilling into a flush beat
        run_t2();
        drain();

        // T3: N=4, beat 0 dropped, rest untouched
        exp_hdr(32'hDEADBEEF, 4'b1111, 1'b0);
        exp_beat(32'h01020304, 4'b1111, 1'b0);
        exp_beat(32'h05060708, 4'b1111, 1'b1);
        send_cmd(3'd4);
        send_beat(32'hDEADBEEF, 4'b1111, 1'b0);
        send_beat(32'h01020304, 4'b1111, 1'b0);
        send_beat(32'h05060708, 4'b1111, 1'b1);
        drain();

        // Oversized count clamps to a full word
        exp_hdr(32'hAABBCCDD, 4'b1111, 1'b0);
        exp_beat(32'h11223344, 4'b1111, 1'b1);
        send_cmd(3'd7);
        send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
        send_beat(32'h11223344, 4'b1111, 1'b1);
        drain();

        // T4: N=0 passthrough, one-cycle latency
        exp_hdr(32'h00000000, 4'b0000, 1'b0);
        exp_beat(32'h01020304, 4'b1111, 1'b0);
        exp_beat(32'h05060708, 4'b1111, 1'b0);
        exp_beat(32'h090A0B00, 4'b1110, 1'b1);
        send_cmd(3'd0);
        send_beat(32'h01020304, 4'b1111, 1'b0);
        chk("t4_latency_valid", 32'(m_out.valid), 32'd1);
        chk("t4_latency_data", m_out.data, 32'h01020304);
        send_beat(32'h05060708, 4'b1111, 1'b0);
        send_beat(32'h090A0BFF, 4'b1110, 1'b1);
        drain();

        // T5: single short beat, no data emitted
        exp_hdr(32'h0000DDEE, 4'b0011, 1'b1);
        send_cmd(3'd3);
        send_beat(32'hDDEEFF77, 4'b1100, 1'b1);
        drain();

        // Single beat with k == N is still short
        exp_hdr(32'h00001234, 4'b0011, 1'b1);
        send_cmd(3'd2);
        send_beat(32'h12345678, 4'b1100, 1'b1);
        drain();

        // Single beat with k > N emits payload directly
        exp_hdr(32'h000000A1, 4'b0001, 1'b0);
        exp_beat(32'hB2C30000, 4'b1100, 1'b1);
        send_cmd(3'd1);
        send_beat(32'hA1B2C3D4, 4'b1110, 1'b1);
        drain();

        // T6: T2 under backpressure
        bp_idx = 0;
        bp_en = 1'b1;
        run_t2();
        drain();
        bp_en = 1'b0;
        rdy_hold = 1'b1;
        @(posedge clk); #1;

        // Reset in mid-packet with an output beat held
        rdy_hold = 1'b0;
        exp_hdr(32'h00001122, 4'b0011, 1'b0);
        send_cmd(3'd2);
        send_beat(32'h11223344, 4'b1111, 1'b0);
        send_beat(32'h55667788, 4'b1111, 1'b0);
        chk("abort_pending", 32'(m_out.valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_valid_out", 32'(m_out.valid), 32'd0);
        chk("abort_data_out", m_out.data, 32'd0);
        chk("abort_ready_in", 32'(s_in.ready), 32'd0);
        chk("abort_ready_strip", 32'(ready_strip), 32'd0);
        chk("abort_valid_header", 32'(valid_header), 32'd0);
        exp_q.delete();
        hdr_q.delete();
        rdy_hold = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_t1();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
